// File: rtl/trans_layer_param.sv
// Transaction layer: main FIFO routed by destination field into per-channel FIFOs with
// almost-full flow control and readable pop counters. Optional feature macro: TRANS_DROP_CNT_EN.
module trans_layer_param #(
    parameter int DATA_SIZE = 12,
    parameter int NUM_CH    = 4,
    parameter int CH_SEL_W  = 2,
    parameter int MAIN_AW   = 3,
    parameter int CH_AW     = 2,
    parameter int CNT_SIZE  = 5
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic                        init,
    input  logic [DATA_SIZE-1:0]        data_in,
    input  logic                        push,
    input  logic [NUM_CH-1:0]           pop,
    input  logic [CH_AW:0]              th_almost_full,
    input  logic [CH_AW:0]              th_almost_empty,
    input  logic                        req,
    input  logic [CH_SEL_W-1:0]         idx,
    output logic [NUM_CH*DATA_SIZE-1:0] data_out,
    output logic [NUM_CH-1:0]           valid_out,
    output logic [CNT_SIZE-1:0]         data_out_cont,
    output logic                        valid_cont,
    output logic                        main_full,
    output logic [NUM_CH-1:0]           ch_almost_full,
    output logic [NUM_CH-1:0]           ch_almost_empty,
    output logic                        idle
`ifdef TRANS_DROP_CNT_EN
    ,
    output logic [CNT_SIZE-1:0]         drop_cnt
`endif
);

    localparam int                  MAIN_DEPTH_N = 2 ** MAIN_AW;
    localparam int                  CH_DEPTH_N   = 2 ** CH_AW;
    localparam logic [MAIN_AW:0]    MAIN_DEPTH   = {1'b1, {MAIN_AW{1'b0}}};
    localparam logic [CH_AW:0]      CH_DEPTH     = {1'b1, {CH_AW{1'b0}}};
    localparam logic [CH_AW:0]      TH_AF_RST    = {1'b0, {CH_AW{1'b1}}};

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t                 state_q, state_d;
    logic [CH_AW:0]         th_af_q, th_ae_q;

    logic [DATA_SIZE-1:0]   main_mem_q [MAIN_DEPTH_N];
    logic [MAIN_AW-1:0]     main_wr_q, main_rd_q;
    logic [MAIN_AW:0]       main_cnt_q;

    logic [DATA_SIZE-1:0]   ch_mem_q   [NUM_CH][CH_DEPTH_N];
    logic [CH_AW-1:0]       ch_wr_q    [NUM_CH];
    logic [CH_AW-1:0]       ch_rd_q    [NUM_CH];
    logic [CH_AW:0]         ch_cnt_q   [NUM_CH];
    logic [CNT_SIZE-1:0]    pop_cnt_q  [NUM_CH];

    logic [NUM_CH*DATA_SIZE-1:0] data_out_q;
    logic [NUM_CH-1:0]      valid_out_q;
    logic [CNT_SIZE-1:0]    cont_q, cont_sel;
    logic                   valid_cont_q;

    logic                   io_ok, xfer_ok, main_empty, xfer, push_acc, busy;
    logic [DATA_SIZE-1:0]   head;
    logic [CH_SEL_W-1:0]    dest;
    logic [NUM_CH-1:0]      ch_wr_en, ch_rd_en;

    // push/pop are live everywhere except RESET; transfers and counter reads only when settled
    assign io_ok      = (state_q != ST_RESET);
    assign xfer_ok    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign main_empty = (main_cnt_q == '0);
    assign main_full  = (main_cnt_q == MAIN_DEPTH);
    assign head       = main_mem_q[main_rd_q];
    assign dest       = head[DATA_SIZE-1 -: CH_SEL_W];

    // Head-of-line blocking: a stalled head holds back every word behind it.
    assign xfer     = xfer_ok && !main_empty && !ch_almost_full[dest] && (ch_cnt_q[dest] != CH_DEPTH);
    assign push_acc = io_ok && push && (!main_full || xfer);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        ch_almost_full  = '0;
        ch_almost_empty = '0;
        ch_rd_en        = '0;
        busy            = !main_empty;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_almost_full[k]  = (ch_cnt_q[k] >= th_af_q);
            ch_almost_empty[k] = (ch_cnt_q[k] <= th_ae_q);
            ch_rd_en[k]        = io_ok && pop[k] && (ch_cnt_q[k] != '0);
            busy               = busy || (ch_cnt_q[k] != '0);
        end
    end

    always_comb begin
        ch_wr_en = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_wr_en[k] = xfer && (dest == CH_SEL_W'(k));
        end
    end

`ifdef TRANS_DROP_CNT_EN
    localparam logic [CH_SEL_W-1:0] LAST_CH = CH_SEL_W'(NUM_CH - 1);
    logic                drop;
    logic [CNT_SIZE-1:0] drop_q;

    assign drop     = io_ok && push && main_full && !xfer;
    assign drop_cnt = drop_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end
`endif

    always_comb begin
        cont_sel = pop_cnt_q[idx];
`ifdef TRANS_DROP_CNT_EN
        if ((idx == LAST_CH) && pop[NUM_CH-1]) begin
            cont_sel = drop_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (init) state_d = ST_INIT; else if (busy) state_d = ST_ACTIVE;
            ST_ACTIVE: if (init) state_d = ST_INIT; else if (!busy) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
            th_af_q <= TH_AF_RST;
            th_ae_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                th_af_q <= th_almost_full;
                th_ae_q <= th_almost_empty;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            main_wr_q  <= '0;
            main_rd_q  <= '0;
            main_cnt_q <= '0;
        end else begin
            if (push_acc) main_wr_q <= main_wr_q + 1'b1;
            if (xfer)     main_rd_q <= main_rd_q + 1'b1;
            if (push_acc && !xfer)      main_cnt_q <= main_cnt_q + 1'b1;
            else if (!push_acc && xfer) main_cnt_q <= main_cnt_q - 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; pointers and counts alone define valid contents.
    always_ff @(posedge clk) begin
        if (push_acc) main_mem_q[main_wr_q] <= data_in;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_wr_en[k]) ch_mem_q[k][ch_wr_q[k]] <= head;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ch_wr_q[k]   <= '0;
                ch_rd_q[k]   <= '0;
                ch_cnt_q[k]  <= '0;
                pop_cnt_q[k] <= '0;
            end
            data_out_q  <= '0;
            valid_out_q <= '0;
        end else begin
            valid_out_q <= ch_rd_en;
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_wr_en[k]) ch_wr_q[k] <= ch_wr_q[k] + 1'b1;
                if (ch_rd_en[k]) begin
                    ch_rd_q[k]   <= ch_rd_q[k] + 1'b1;
                    pop_cnt_q[k] <= pop_cnt_q[k] + 1'b1;
                    data_out_q[k*DATA_SIZE +: DATA_SIZE] <= ch_mem_q[k][ch_rd_q[k]];
                end
                if (ch_wr_en[k] && !ch_rd_en[k])      ch_cnt_q[k] <= ch_cnt_q[k] + 1'b1;
                else if (!ch_wr_en[k] && ch_rd_en[k]) ch_cnt_q[k] <= ch_cnt_q[k] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cont_q       <= '0;
            valid_cont_q <= 1'b0;
        end else begin
            valid_cont_q <= xfer_ok && req;
            if (xfer_ok && req) cont_q <= cont_sel;
        end
    end

    assign data_out      = data_out_q;
    assign valid_out     = valid_out_q;
    assign data_out_cont = cont_q;
    assign valid_cont    = valid_cont_q;
    assign idle          = (state_q == ST_IDLE);

endmodule

// File: tb/tb_trans_layer_param.sv
// Bench for trans_layer_param: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_trans_layer_param;

    localparam int DATA_SIZE  = 12;
    localparam int NUM_CH     = 4;
    localparam int CH_SEL_W   = 2;
    localparam int CNT_SIZE   = 5;
    localparam int MAIN_DEPTH = 8;
    localparam int CH_DEPTH   = 4;
    localparam int CNT_MOD    = 32;
    localparam int P_RESET = 0, P_INIT = 1, P_IDLE = 2, P_ACTIVE = 3;

    logic                        clk = 1'b0;
    logic                        reset_L, init, push, req;
    logic [DATA_SIZE-1:0]        data_in;
    logic [NUM_CH-1:0]           pop;
    logic [2:0]                  th_almost_full, th_almost_empty;
    logic [CH_SEL_W-1:0]         idx;
    logic [NUM_CH*DATA_SIZE-1:0] data_out;
    logic [NUM_CH-1:0]           valid_out, ch_almost_full, ch_almost_empty;
    logic [CNT_SIZE-1:0]         data_out_cont;
    logic                        valid_cont, main_full, idle;
`ifdef TRANS_DROP_CNT_EN
    logic [CNT_SIZE-1:0]         drop_cnt;
`endif

    always #5 clk = ~clk;

    trans_layer_param dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .init            (init),
        .data_in         (data_in),
        .push            (push),
        .pop             (pop),
        .th_almost_full  (th_almost_full),
        .th_almost_empty (th_almost_empty),
        .req             (req),
        .idx             (idx),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .data_out_cont   (data_out_cont),
        .valid_cont      (valid_cont),
        .main_full       (main_full),
        .ch_almost_full  (ch_almost_full),
        .ch_almost_empty (ch_almost_empty),
        .idle            (idle)
`ifdef TRANS_DROP_CNT_EN
        ,
        .drop_cnt        (drop_cnt)
`endif
    );

    // Reference model: word queues plus the few registers the outputs are defined by.
    logic [DATA_SIZE-1:0] mq[$];
    logic [DATA_SIZE-1:0] cq[NUM_CH][$];
    int                   m_phase, m_th_af, m_th_ae, m_drop;
    int                   m_cnt[NUM_CH];
    logic [DATA_SIZE-1:0] exp_dout[NUM_CH];
    logic [NUM_CH-1:0]    exp_vout;
    int                   exp_cont;
    bit                   exp_vcont;
    bit                   armed = 1'b0;
    int                   n_total = 0;
    int                   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        for (int k = 0; k < NUM_CH; k++) begin
            cq[k].delete();
            m_cnt[k]    = 0;
            exp_dout[k] = '0;
        end
        exp_vout  = '0;
        exp_cont  = 0;
        exp_vcont = 1'b0;
        m_drop    = 0;
        m_phase   = P_RESET;
        m_th_af   = CH_DEPTH - 1;
        m_th_ae   = 0;
    endfunction

    function automatic void model_step();
        bit                   io, settled, xf, busy;
        int                   d;
        logic [DATA_SIZE-1:0] w;
        io      = (m_phase != P_RESET);
        settled = (m_phase == P_IDLE) || (m_phase == P_ACTIVE);
        busy    = (mq.size() != 0);
        for (int k = 0; k < NUM_CH; k++) busy = busy || (cq[k].size() != 0);

        // Counter read sees the pre-increment value.
        if (settled && req) begin
            exp_vcont = 1'b1;
            exp_cont  = m_cnt[idx];
`ifdef TRANS_DROP_CNT_EN
            if ((int'(idx) == NUM_CH - 1) && pop[NUM_CH-1]) exp_cont = m_drop;
`endif
        end else begin
            exp_vcont = 1'b0;
        end

        xf = 1'b0;
        d  = 0;
        w  = '0;
        if (settled && (mq.size() != 0)) begin
            w = mq[0];
            d = int'(w[DATA_SIZE-1 -: CH_SEL_W]);
            if ((cq[d].size() < m_th_af) && (cq[d].size() < CH_DEPTH)) xf = 1'b1;
        end

        for (int k = 0; k < NUM_CH; k++) begin
            if (io && pop[k] && (cq[k].size() != 0)) begin
                exp_dout[k] = cq[k].pop_front();
                exp_vout[k] = 1'b1;
                m_cnt[k]    = (m_cnt[k] + 1) % CNT_MOD;
            end else begin
                exp_vout[k] = 1'b0;
            end
        end

        if (xf) begin
            void'(mq.pop_front());
            cq[d].push_back(w);
        end

        if (io && push) begin
            if (mq.size() < MAIN_DEPTH) mq.push_back(data_in);
            else if (m_drop < CNT_MOD - 1) m_drop++;
        end

        case (m_phase)
            P_RESET: m_phase = P_INIT;
            P_INIT: begin
                m_th_af = int'(th_almost_full);
                m_th_ae = int'(th_almost_empty);
                m_phase = P_IDLE;
            end
            default: m_phase = init ? P_INIT : (busy ? P_ACTIVE : P_IDLE);
        endcase
    endfunction

    task automatic compare_all();
        logic [NUM_CH*DATA_SIZE-1:0] dexp;
        logic [NUM_CH-1:0]           af, ae;
        for (int k = 0; k < NUM_CH; k++) begin
            dexp[k*DATA_SIZE +: DATA_SIZE] = exp_dout[k];
            af[k] = (cq[k].size() >= m_th_af);
            ae[k] = (cq[k].size() <= m_th_ae);
        end
        check("data_out", data_out, dexp);
        check("valid_out", valid_out, exp_vout);
        check("data_out_cont", data_out_cont, exp_cont);
        check("valid_cont", valid_cont, exp_vcont);
        check("main_full", main_full, mq.size() == MAIN_DEPTH);
        check("ch_almost_full", ch_almost_full, af);
        check("ch_almost_empty", ch_almost_empty, ae);
        check("idle", idle, m_phase == P_IDLE);
`ifdef TRANS_DROP_CNT_EN
        check("drop_cnt", drop_cnt, m_drop);
`endif
    endtask

    always @(posedge clk) if (armed && reset_L) model_step();

    always @(posedge clk) begin
        #2;
        if (armed) compare_all();
    end

    task automatic send(input logic [DATA_SIZE-1:0] w);
        data_in = w;
        push    = 1'b1;
        @(negedge clk);
        push    = 1'b0;
    endtask

    task automatic pulse_init(input logic [2:0] af);
        th_almost_full = af;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
    endtask

    task automatic assert_reset();
        reset_L = 1'b0;
        model_reset();
        armed = 1'b1;
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_main_full", main_full, 0);
        check("rst_almost_full", ch_almost_full, 0);
        check("rst_almost_empty", ch_almost_empty, 4'hF);
        check("rst_idle", idle, 0);
        check("rst_valid_cont", valid_cont, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want self-termination");
        $fatal(1);
    end

    initial begin
        logic [DATA_SIZE-1:0] w;
        int seen;
        reset_L = 1'b1; init = 1'b0; push = 1'b0; pop = '0; req = 1'b0; idx = '0;
        data_in = '0; th_almost_full = 3'd3; th_almost_empty = 3'd0;

        // Reset/init: clock period is 10 units, so 3000 is 3 us at a 1 ns unit.
        #3000;
        assert_reset();
        repeat (3) @(negedge clk);
        reset_L = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_two_cycles_after_release", idle, 1);

        // Routing by destination field.
        send(12'h005); send(12'h408); send(12'h80A); send(12'hC0F);
        repeat (4) @(negedge clk);
        pop = '1;
        @(negedge clk);
        pop = '0;
        check("route_data_out", data_out, 48'hC0F_80A_408_005);
        check("route_valid_out", valid_out, 4'b1111);
        @(negedge clk);
        check("route_valid_one_cycle", valid_out, 4'b0000);

        // Flow control with almost-full threshold 2 and a head-of-line word for channel 2.
        pulse_init(3'd2);
        for (int i = 1; i <= 5; i++) send(12'h400 | 12'(i));
        send(12'h800);
        repeat (6) @(negedge clk);
        check("fc_ch1_almost_full", ch_almost_full[1], 1);
        check("fc_ch2_empty", ch_almost_empty[2], 1);
        pop = 4'b0010;
        @(negedge clk);
        pop = '0;
        check("fc_ch1_head", data_out[1*DATA_SIZE +: DATA_SIZE], 12'h401);
        check("fc_ch1_valid", valid_out[1], 1);
        @(negedge clk);
        pop = 4'b0100;
        @(negedge clk);
        pop = '0;
        check("fc_hol_ch2_not_valid", valid_out[2], 0);
        check("fc_ch2_slice_holds", data_out[2*DATA_SIZE +: DATA_SIZE], 12'h80A);
        pop = '1;
        repeat (12) @(negedge clk);
        pop = '0;
        @(negedge clk);
        check("fc_drained_empty", ch_almost_empty, 4'hF);
        check("fc_drained_idle", idle, 1);

        // Overflow: threshold 0 blocks every transfer.
        pulse_init(3'd0);
        for (int i = 0; i < 10; i++) begin
            w = 12'(i);
            w[11:10] = w[1:0];
            send(w);
        end
        check("ovf_main_full", main_full, 1);
`ifdef TRANS_DROP_CNT_EN
        check("ovf_drop_cnt", drop_cnt, 2);
        req = 1'b1; idx = 2'd3; pop = 4'b1000;
        @(negedge clk);
        req = 1'b0; pop = '0;
        check("ovf_drop_read", data_out_cont, 2);
        check("ovf_drop_read_valid", valid_cont, 1);
`endif
        pulse_init(3'd3);
        seen = 0;
        pop = '1;
        repeat (20) begin
            @(negedge clk);
            seen += $countones(valid_out);
        end
        pop = '0;
        check("ovf_words_kept", seen, 8);

        // Reset in the middle of operation.
        pulse_init(3'd0);
        for (int i = 0; i < 5; i++) send(12'h030 + 12'(i));
        th_almost_full = 3'd3;
        assert_reset();
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_idle", idle, 1);
        pop = '1;
        @(negedge clk);
        pop = '0;
        check("midrst_pop_empty", valid_out, 0);

        // Counter wrap: 33 pops on channel 0 read back as 1.
        pop = 4'b0001;
        for (int i = 0; i < 33; i++) send(12'(i));
        repeat (8) @(negedge clk);
        pop = '0;
        req = 1'b1; idx = 2'd0;
        @(negedge clk);
        req = 1'b0;
        check("cnt_wrap_value", data_out_cont, 1);
        check("cnt_wrap_valid", valid_cont, 1);
        @(negedge clk);
        check("cnt_req_low_valid", valid_cont, 0);
        check("cnt_req_low_hold", data_out_cont, 1);

        // Randomized traffic with occasional re-init and one reset.
        for (int n = 0; n < 700; n++) begin
            push            = ($urandom_range(0, 3) != 0);
            data_in         = 12'($urandom);
            pop             = 4'($urandom);
            req             = 1'($urandom);
            idx             = 2'($urandom);
            init            = ($urandom_range(0, 29) == 0);
            th_almost_full  = 3'($urandom_range(0, 5));
            th_almost_empty = 3'($urandom_range(0, 4));
            if (n == 350) begin
                assert_reset();
                @(negedge clk);
                reset_L = 1'b1;
            end
            @(negedge clk);
        end
        push = 1'b0; pop = '0; req = 1'b0; init = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
